// File: rtl/zone_stat_accum.sv
// Per-zone max/mean/backlight statistics for a mini-LED zone grid, fed by the gray pixel stream.
// Results leave one zone row at a time through a valid/ready serializer.
module zone_stat_accum #(
  parameter int H_ACT     = 1280,
  parameter int V_ACT     = 800,
  parameter int ZONE_W    = 80,
  parameter int ZONE_H    = 80,
  parameter int ZONES_X   = 16,
  parameter int ZONES_Y   = 10,
  parameter int AVG_MUL   = 655,
  parameter int AVG_SHIFT = 22,
  parameter int BL_MODE   = 2
) (
  input  logic        i_pix_clk,
  input  logic        rst,
  input  logic        gray_valid,
  input  logic [7:0]  gray,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic        zone_valid,
  input  logic        zone_ready,
  output logic [3:0]  zone_x,
  output logic [3:0]  zone_y,
  output logic [7:0]  zone_max,
  output logic [7:0]  zone_avg,
  output logic [7:0]  zone_bl,
  output logic        frame_done,
  output logic        ovf
);

  localparam int XIW = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
  localparam int YIW = (ZONE_H > 1) ? $clog2(ZONE_H) : 1;
  localparam int ZXW = $clog2(ZONES_X + 1);
  localparam int ZYW = $clog2(ZONES_Y + 1);
  localparam int XW  = (ZONES_X > 1) ? $clog2(ZONES_X) : 1;

  localparam logic [XIW-1:0] X_LAST  = XIW'(ZONE_W - 1);
  localparam logic [YIW-1:0] Y_LAST  = YIW'(ZONE_H - 1);
  localparam logic [ZXW-1:0] ZX_NUM  = ZXW'(ZONES_X);
  localparam logic [XW-1:0]  XI_LAST = XW'(ZONES_X - 1);
  localparam logic [ZYW-1:0] ZY_LAST = ZYW'(ZONES_Y - 1);
  localparam logic [10:0]    PX_LAST = 11'(H_ACT);
  localparam logic [10:0]    PY_LAST = 11'(V_ACT);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [XIW-1:0] x_in, x_eff;
  logic [YIW-1:0] y_in, y_eff;
  logic [ZXW-1:0] zx, zx_eff;
  logic [ZYW-1:0] zy, zy_eff;
  logic [XW-1:0]  col;
  logic           beat, line_start, frame_start, line_end, first_px, col_ok, row_end;

  logic [7:0]     max_acc [ZONES_X];
  logic [20:0]    sum_acc [ZONES_X];
  logic [7:0]     avg_calc [ZONES_X];
  logic [7:0]     bl_calc [ZONES_X];

  logic           row_end_q;
  logic [ZYW-1:0] row_zy_q;

  logic [0:0]     state;
  logic [XW-1:0]  x_idx;
  logic [ZYW-1:0] bank_zy;
  logic [7:0]     bank_max [ZONES_X];
  logic [7:0]     bank_avg [ZONES_X];
  logic [7:0]     bank_bl [ZONES_X];
  logic           load, xfer;

  // Line/frame starts override the running counters so the position re-syncs every line.
  // NOTE: every output of this block is assigned on every pass, so no latch can be inferred.
  always_comb begin
    line_start  = (pix_x == 11'd1);
    frame_start = line_start && (pix_y == 11'd1);
    line_end    = (pix_x == PX_LAST);
    beat        = gray_valid && (pix_x != 11'd0) && (pix_x <= PX_LAST) &&
                  (pix_y != 11'd0) && (pix_y <= PY_LAST);
    x_eff       = line_start  ? '0 : x_in;
    zx_eff      = line_start  ? '0 : zx;
    y_eff       = frame_start ? '0 : y_in;
    zy_eff      = frame_start ? '0 : zy;
    col_ok      = (zx_eff < ZX_NUM);
    col         = zx_eff[XW-1:0];
    first_px    = (x_eff == '0) && (y_eff == '0);
    row_end     = beat && line_end && (y_eff == Y_LAST);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_pix_clk) begin
    if (rst) begin
      x_in      <= '0;
      zx        <= '0;
      y_in      <= '0;
      zy        <= '0;
      row_end_q <= 1'b0;
      row_zy_q  <= '0;
      // NOTE: the accumulator array is cleared too, so a mid-frame reset never leaks partial zones.
      for (int c = 0; c < ZONES_X; c++) begin
        max_acc[c] <= '0;
        sum_acc[c] <= '0;
      end
    end else begin
      row_end_q <= row_end;
      if (row_end) row_zy_q <= zy_eff;
      if (beat) begin
        if (x_eff == X_LAST) begin
          x_in <= '0;
          zx   <= zx_eff + 1'b1;
        end else begin
          x_in <= x_eff + 1'b1;
          zx   <= zx_eff;
        end
        y_in <= y_eff;
        zy   <= zy_eff;
        if (line_end) begin
          if (y_eff == Y_LAST) begin
            y_in <= '0;
            zy   <= zy_eff + 1'b1;
          end else begin
            y_in <= y_eff + 1'b1;
          end
        end
        if (col_ok) begin
          if (first_px) begin
            max_acc[col] <= gray;
            sum_acc[col] <= 21'(gray);
          end else begin
            max_acc[col] <= (gray > max_acc[col]) ? gray : max_acc[col];
            sum_acc[col] <= sum_acc[col] + 21'(gray);
          end
        end
      end
    end
  end

  // Mean via reciprocal multiply, saturated to 8 bits; backlight blends max and mean.
  for (genvar c = 0; c < ZONES_X; c++) begin : g_col
    logic [30:0] prod;
    logic [30:0] quo;
    logic [8:0]  blsum;
    assign prod        = 31'(sum_acc[c]) * 31'(AVG_MUL);
    assign quo         = prod >> AVG_SHIFT;
    assign avg_calc[c] = (quo > 31'd255) ? 8'd255 : quo[7:0];
    assign blsum       = {1'b0, max_acc[c]} + {1'b0, avg_calc[c]};
    assign bl_calc[c]  = (BL_MODE == 0) ? max_acc[c] :
                         (BL_MODE == 1) ? avg_calc[c] : 8'(blsum >> 1);
  end

  assign load = row_end_q && (state == S_IDLE);
  assign xfer = (state == S_SEND) && zone_ready;

  always_ff @(posedge i_pix_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x_idx      <= '0;
      bank_zy    <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      for (int c = 0; c < ZONES_X; c++) begin
        bank_max[c] <= '0;
        bank_avg[c] <= '0;
        bank_bl[c]  <= '0;
      end
    end else begin
      frame_done <= xfer && (x_idx == XI_LAST) && (bank_zy == ZY_LAST);
      if (row_end_q && (state != S_IDLE)) ovf <= 1'b1;
      if (load) begin
        state   <= S_SEND;
        x_idx   <= '0;
        bank_zy <= row_zy_q;
        for (int c = 0; c < ZONES_X; c++) begin
          bank_max[c] <= max_acc[c];
          bank_avg[c] <= avg_calc[c];
          bank_bl[c]  <= bl_calc[c];
        end
      end else if (xfer) begin
        if (x_idx == XI_LAST) begin
          state <= S_IDLE;
          x_idx <= '0;
        end else begin
          x_idx <= x_idx + 1'b1;
        end
      end
    end
  end

  assign zone_valid = (state == S_SEND);
  assign zone_x     = 4'(x_idx);
  assign zone_y     = 4'(bank_zy);
  assign zone_max   = bank_max[x_idx];
  assign zone_avg   = bank_avg[x_idx];
  assign zone_bl    = bank_bl[x_idx];

endmodule

// File: tb/tb_zone_stat_accum.sv
// Bench for zone_stat_accum on a reduced grid: random frames are scored against per-zone
// statistics computed directly from the stored image.
module tb_zone_stat_accum;

  localparam int H_ACT     = 32;
  localparam int V_ACT     = 16;
  localparam int ZONE_W    = 8;
  localparam int ZONE_H    = 4;
  localparam int ZONES_X   = 4;
  localparam int ZONES_Y   = 4;
  localparam int AVG_MUL   = 131000;
  localparam int AVG_SHIFT = 22;
  localparam int BL_MODE   = 2;

  localparam logic [3:0] LAST_ZX = 4'(ZONES_X - 1);
  localparam logic [3:0] LAST_ZY = 4'(ZONES_Y - 1);

  logic        i_pix_clk;
  logic        rst;
  logic        gray_valid;
  logic [7:0]  gray;
  logic [10:0] pix_x, pix_y;
  logic        zone_valid, zone_ready;
  logic [3:0]  zone_x, zone_y;
  logic [7:0]  zone_max, zone_avg, zone_bl;
  logic        frame_done, ovf;

  int          checks, errors;
  int          cyc;
  int          ready_mode, ovf_mode;
  int          fd_exp, fd_count, stall_x2;
  logic [7:0]  img [V_ACT][H_ACT];
  logic [31:0] exp_q [$];
  int          rowend_q [$];

  zone_stat_accum #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .ZONE_W(ZONE_W), .ZONE_H(ZONE_H),
    .ZONES_X(ZONES_X), .ZONES_Y(ZONES_Y), .AVG_MUL(AVG_MUL),
    .AVG_SHIFT(AVG_SHIFT), .BL_MODE(BL_MODE)
  ) dut (
    .i_pix_clk (i_pix_clk),
    .rst       (rst),
    .gray_valid(gray_valid),
    .gray      (gray),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .zone_valid(zone_valid),
    .zone_ready(zone_ready),
    .zone_x    (zone_x),
    .zone_y    (zone_y),
    .zone_max  (zone_max),
    .zone_avg  (zone_avg),
    .zone_bl   (zone_bl),
    .frame_done(frame_done),
    .ovf       (ovf)
  );

  initial begin
    i_pix_clk = 1'b0;
    forever #5 i_pix_clk = ~i_pix_clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge i_pix_clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_pix_clk);
    #1;
  endtask

  // Reference: one zone row straight from the image with plain arithmetic.
  task automatic push_row(input int zr);
    for (int zc = 0; zc < ZONES_X; zc++) begin
      int     mx, sm, bl;
      longint avg;
      mx = 0;
      sm = 0;
      for (int yy = zr * ZONE_H; yy < (zr + 1) * ZONE_H; yy++)
        for (int xx = zc * ZONE_W; xx < (zc + 1) * ZONE_W; xx++) begin
          if (int'(img[yy][xx]) > mx) mx = int'(img[yy][xx]);
          sm += int'(img[yy][xx]);
        end
      avg = (longint'(sm) * AVG_MUL) >>> AVG_SHIFT;
      if (avg > 255) avg = 255;
      if (BL_MODE == 0)      bl = mx;
      else if (BL_MODE == 1) bl = int'(avg);
      else                   bl = (mx + int'(avg)) / 2;
      exp_q.push_back({4'(zc), 4'(zr), 8'(mx), 8'(avg), 8'(bl)});
    end
  endtask

  // pat: 0 uniform 100, 1 single 255 pixel in zone (1,0), 2 all 255, 3 random.
  task automatic frame(input int pat, input int abort_line);
    for (int y = 0; y < V_ACT; y++)
      for (int x = 0; x < H_ACT; x++)
        case (pat)
          0:       img[y][x] = 8'd100;
          1:       img[y][x] = (y == 0 && x == ZONE_W) ? 8'd255 : 8'd0;
          2:       img[y][x] = 8'd255;
          default: img[y][x] = 8'($urandom_range(0, 255));
        endcase
    for (int y = 1; y <= V_ACT; y++) begin
      for (int x = 1; x <= H_ACT; x++) begin
        if (y == abort_line && x == H_ACT / 2) begin
          gray_valid = 1'b0;
          return;
        end
        if ($urandom_range(0, 7) == 0) begin
          gray_valid = 1'b0;
          pix_x      = 11'($urandom_range(0, 2047));
          gray       = 8'($urandom);
          step();
        end
        gray_valid = 1'b1;
        pix_x      = 11'(x);
        pix_y      = 11'(y);
        gray       = img[y-1][x-1];
        if (x == H_ACT && y % ZONE_H == 0 && (ovf_mode == 0 || y == ZONE_H)) begin
          rowend_q.push_back(cyc);
          push_row(y / ZONE_H - 1);
        end
        step();
      end
      gray_valid = 1'b1;
      pix_x      = 11'(H_ACT + 1 + $urandom_range(0, 5));
      gray       = 8'hFF;
      step();
      gray_valid = 1'b0;
      pix_x      = 11'd0;
      step();
      step();
    end
    gray_valid = 1'b0;
    if (ovf_mode == 0) fd_exp++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || zone_valid) && n < 3000) begin
      step();
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // Consumer: 0 always ready, 1 random, 2 three-cycle stall on zone_x==2, 3 never ready.
  initial begin
    zone_ready = 1'b1;
    forever begin
      @(posedge i_pix_clk);
      #1;
      case (ready_mode)
        0: zone_ready = 1'b1;
        1: zone_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (zone_valid && zone_x == 4'd2 && zone_ready) begin
            zone_ready = 1'b0;
            repeat (3) @(posedge i_pix_clk);
            #1;
          end
          zone_ready = 1'b1;
        end
        default: zone_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard order, hold stability, valid latency and frame_done timing.
  initial begin
    logic        prev_stall, prev_valid, fd_pending;
    logic [31:0] prev_out, cur, e;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    fd_pending = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge i_pix_clk);
      cur = {zone_x, zone_y, zone_max, zone_avg, zone_bl};
      if (rst) begin
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        fd_pending = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(zone_valid), 32'd1);
        check("hold_data", cur, prev_out);
      end
      if (zone_valid && !prev_valid) begin
        if (rowend_q.size() == 0) check("latency_unexpected", rowend_q.size(), 1);
        else check("latency", cyc - rowend_q.pop_front(), 2);
      end
      if (fd_pending || frame_done) check("frame_done", 32'(frame_done), 32'(fd_pending));
      if (frame_done) fd_count++;
      fd_pending = 1'b0;
      if (zone_valid && zone_ready) begin
        if (exp_q.size() == 0) check("zone_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("zone", cur, e);
          fd_pending = (e[31:28] == LAST_ZX) && (e[27:24] == LAST_ZY);
        end
      end
      if (zone_valid && !zone_ready && zone_x == 4'd2) stall_x2++;
      prev_stall = zone_valid && !zone_ready;
      prev_out   = cur;
      prev_valid = zone_valid;
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    ready_mode = 0;
    ovf_mode   = 0;
    fd_exp     = 0;
    fd_count   = 0;
    stall_x2   = 0;
    rst        = 1'b1;
    gray_valid = 1'b0;
    gray       = '0;
    pix_x      = '0;
    pix_y      = '0;
    repeat (3) step();
    check("reset_data", {zone_x, zone_y, zone_max, zone_avg, zone_bl}, 32'd0);
    check("reset_flags", 32'({zone_valid, frame_done, ovf}), 32'd0);
    rst = 1'b0;
    step();

    frame(0, 0);
    drain("drain_uniform");
    frame(1, 0);
    drain("drain_single");
    frame(2, 0);
    drain("drain_white");

    ready_mode = 1;
    frame(3, 0);
    drain("drain_random_ready");

    ready_mode = 2;
    stall_x2   = 0;
    frame(3, 0);
    drain("drain_stall");
    check("stall_cycles", stall_x2, 3 * ZONES_Y);
    check("ovf_clear", 32'(ovf), 32'd0);

    ready_mode = 3;
    ovf_mode   = 1;
    frame(3, 0);
    repeat (5) step();
    check("ovf_set", 32'(ovf), 32'd1);
    check("ovf_held_valid", 32'(zone_valid), 32'd1);
    check("ovf_held_x", 32'(zone_x), 32'd0);
    ready_mode = 0;
    ovf_mode   = 0;
    drain("drain_ovf");
    check("ovf_sticky", 32'(ovf), 32'd1);

    frame(3, 10);
    drain("drain_before_reset");
    rst = 1'b1;
    step();
    check("midrst_data", {zone_x, zone_y, zone_max, zone_avg, zone_bl}, 32'd0);
    check("midrst_flags", 32'({zone_valid, frame_done, ovf}), 32'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    rowend_q.delete();
    step();

    frame(3, 0);
    drain("drain_after_reset");

    repeat (4) step();
    check("frame_done_count", fd_count, fd_exp);
    check("latency_queue_empty", rowend_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
